// File: rtl/psum_drain_sched.sv
// Drains per-column psum FIFOs into a single raster-ordered output stream.
// Row r is taken from FIFO (r mod G_ARRAY_WIDTH); one registered output beat with valid/ready.
module psum_drain_sched #(
    parameter int G_ARRAY_WIDTH = 4,
    parameter int G_DATA_WIDTH  = 16,
    parameter int G_OUT_HEIGHT  = 24,
    parameter int G_OUT_WIDTH   = 24,
    localparam int ROW_W = (G_OUT_HEIGHT  > 1) ? $clog2(G_OUT_HEIGHT)  : 1,
    localparam int COL_W = (G_OUT_WIDTH   > 1) ? $clog2(G_OUT_WIDTH)   : 1,
    localparam int SEL_W = (G_ARRAY_WIDTH > 1) ? $clog2(G_ARRAY_WIDTH) : 1
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       start_i,
    input  logic [0:G_ARRAY_WIDTH-1]                   psum_empty_i,
    input  logic [0:G_ARRAY_WIDTH-1][G_DATA_WIDTH-1:0] psum_i,
    output logic [0:G_ARRAY_WIDTH-1]                   psum_rd_en_o,
    output logic [G_DATA_WIDTH-1:0]                    out_data_o,
    output logic [ROW_W-1:0]                           out_row_o,
    output logic [COL_W-1:0]                           out_col_o,
    output logic                                       out_vld_o,
    input  logic                                       out_rdy_i,
    output logic                                       out_last_o,
    output logic                                       busy_o,
    output logic                                       done_o
);

    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(G_OUT_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(G_OUT_WIDTH - 1);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(G_ARRAY_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [ROW_W-1:0]   row_q;
    logic [COL_W-1:0]   col_q;
    logic [SEL_W-1:0]   sel_q;
    logic               drained_q;
    logic               out_free;
    logic               pop;
    logic               at_last;
    logic               start_layer;

    assign start_layer = (state_q == ST_IDLE) && start_i;
    assign at_last     = (row_q == ROW_MAX) && (col_q == COL_MAX);
    assign out_free    = !out_vld_o || out_rdy_i;
    // drained_q blocks further pops once the final word has been taken
    assign pop         = (state_q == ST_DRAIN) && !drained_q && out_free
                         && !psum_empty_i[sel_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_vld_o && out_rdy_i && out_last_o) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        psum_rd_en_o = '0;
        for (int unsigned i = 0; i < G_ARRAY_WIDTH; i++) begin
            psum_rd_en_o[i] = pop && (sel_q == SEL_W'(i));
        end
        busy_o = (state_q != ST_IDLE);
        done_o = (state_q == ST_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_q     <= '0;
            col_q     <= '0;
            sel_q     <= '0;
            drained_q <= 1'b0;
        end else if (start_layer) begin
            row_q     <= '0;
            col_q     <= '0;
            sel_q     <= '0;
            drained_q <= 1'b0;
        end else if (pop) begin
            if (at_last) begin
                drained_q <= 1'b1;
            end else if (col_q == COL_MAX) begin
                col_q <= '0;
                row_q <= row_q + ROW_W'(1);
                if (sel_q == SEL_MAX) begin
                    sel_q <= '0;
                end else begin
                    sel_q <= sel_q + SEL_W'(1);
                end
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_vld_o  <= 1'b0;
            out_last_o <= 1'b0;
            out_data_o <= '0;
            out_row_o  <= '0;
            out_col_o  <= '0;
        end else if (pop) begin
            out_vld_o  <= 1'b1;
            out_last_o <= at_last;
            out_data_o <= psum_i[sel_q];
            out_row_o  <= row_q;
            out_col_o  <= col_q;
        end else if (out_rdy_i) begin
            out_vld_o  <= 1'b0;
            out_last_o <= 1'b0;
        end
    end

endmodule

// File: doc/psum_drain_sched.md
PSUM_DRAIN_SCHED -- requirements
Module: psum_drain_sched

Interface
REQ-001 SHALL have parameter G_ARRAY_WIDTH, default 4, number of psum FIFOs (one per PE column).
REQ-002 SHALL have parameter G_DATA_WIDTH, default 16, psum word width.
REQ-003 SHALL have parameter G_OUT_HEIGHT, default 24, output feature-map rows.
REQ-004 SHALL have parameter G_OUT_WIDTH, default 24, output feature-map columns.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all state on its rising edge.
REQ-006 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port start_i, input, 1, begin draining one layer.
REQ-008 SHALL have port psum_empty_i, input, [0:G_ARRAY_WIDTH-1], per-FIFO empty flag.
REQ-009 SHALL have port psum_i, input, [0:G_ARRAY_WIDTH-1][G_DATA_WIDTH-1:0], FWFT FIFO head data.
REQ-010 SHALL have port psum_rd_en_o, output, [0:G_ARRAY_WIDTH-1], per-FIFO pop.
REQ-011 SHALL have port out_data_o, output, G_DATA_WIDTH, raster-ordered psum.
REQ-012 SHALL have ports out_row_o / out_col_o, output, $clog2(G_OUT_HEIGHT) / $clog2(G_OUT_WIDTH), coordinates of out_data_o.
REQ-013 SHALL have ports out_vld_o (output, 1), out_rdy_i (input, 1), out_last_o (output, 1; final beat).
REQ-014 SHALL have ports busy_o (output, 1) and done_o (output, 1; one-cycle pulse).

Function
REQ-015 SHALL implement FSM IDLE -> DRAIN -> DONE -> IDLE.
REQ-016 IDLE: on start_i, clear row/col/sel counters to 0 and enter DRAIN; start_i is ignored outside IDLE.
REQ-017 DRAIN: output row r SHALL be taken from FIFO sel = r mod G_ARRAY_WIDTH; G_OUT_WIDTH consecutive words per row.
REQ-018 SHALL assert psum_rd_en_o[sel] only when !psum_empty_i[sel] and the output register is free (out_vld_o==0, or out_vld_o && out_rdy_i in the same cycle).
REQ-019 SHALL never assert psum_rd_en_o for a non-selected FIFO, nor more than one bit per cycle.
REQ-020 On a pop, SHALL capture psum_i[sel] and the current row/col into the output register; out_vld_o rises the next cycle (latency 1 from pop).
REQ-021 Back-to-back pops SHALL sustain one beat per cycle while out_rdy_i==1 and the FIFO is non-empty.
REQ-022 While out_vld_o && !out_rdy_i, out_data_o/out_row_o/out_col_o/out_last_o SHALL hold stable and no pop SHALL occur.
REQ-023 Counters per pop: col increments; at col==G_OUT_WIDTH-1 col wraps to 0, row increments, sel increments, with sel wrapping from G_ARRAY_WIDTH-1 to 0.
REQ-024 An empty selected FIFO SHALL stall the scheduler (no skip to another FIFO); counters hold.
REQ-025 out_last_o SHALL be 1 only on the beat with row==G_OUT_HEIGHT-1 and col==G_OUT_WIDTH-1.
REQ-026 After the last pop, no further pops; on acceptance of the last beat (out_vld_o && out_rdy_i && out_last_o), SHALL enter DONE.
REQ-027 DONE: done_o=1 for exactly one cycle, then IDLE.
REQ-028 busy_o SHALL be 1 in DRAIN and DONE, 0 in IDLE.
REQ-029 out_vld_o SHALL clear the cycle after acceptance if no new pop occurred.

Reset
REQ-030 rst_i SHALL asynchronously force state IDLE, counters 0, out_vld_o=0, out_last_o=0, out_data_o=0, out_row_o=0, out_col_o=0, psum_rd_en_o=0, busy_o=0, done_o=0.
REQ-031 Reset mid-DRAIN SHALL abort without flushing the external FIFOs; an in-flight output beat is discarded.
REQ-032 After reset deassertion, no pop SHALL occur until start_i is seen in IDLE.

Verification (W=4, H=6, Wd=3 -> 18 beats)
REQ-033 All FIFOs pre-filled, out_rdy_i=1, start_i pulse -> 18 consecutive beats, rows 0..5 from FIFOs 0,1,2,3,0,1, out_last_o on beat 18 only, done_o pulse one cycle later.
REQ-034 out_rdy_i toggling 1/0 every cycle -> no pop while stalled, data held stable, 18 beats in order, no loss or duplication.
REQ-035 FIFO 2 empty while row 2 selected, FIFO 3 non-empty -> zero rd_en on all FIFOs until FIFO 2 fills, then resume at (2,0).
REQ-036 rst_i asserted mid-row 3 -> all outputs 0 immediately (asynchronously); start_i afterwards restarts at (0,0) from FIFO 0.
REQ-037 start_i held high during DRAIN and DONE -> no restart; exactly one done_o pulse per start in IDLE.
REQ-038 Assertion across all tests: popcount(psum_rd_en_o)<=1 and no rd_en to an empty FIFO.
